// File: rtl/bcd_ctrl_pkg.sv
// Shared types and 7-segment constants for the BCD counter controller.
// Segment order is {g,f,e,d,c,b,a}, active-low (common-anode display).
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles (10..15) decode to an all-off blank glyph.
module seg7_decode
  import bcd_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear sequencer and 4-digit multiplexed display driver for a BCD counter.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic [15:0] bcdcount,
  output logic        cnt_tick,
  output logic        cnt_clr,
  output logic        run,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);

  state_t        state, state_nxt;
  logic          start_q, clear_q;
  logic          start_edge, clear_edge;
  logic [PW-1:0] p;
  logic          tick_q;
  logic [SW-1:0] sdiv;
  logic [1:0]    k;

  logic [3:0]    nib_p0;
  logic [6:0]    dec_p0;
  logic [6:0]    seg_p0;
  logic          blank_p0;
  logic [3:0]    an_p1;
  logic [6:0]    seg_p1;
  logic          dp_p1;

  // Previous-value flops reset high so a button held through reset gives no edge.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b1;
      clear_q <= 1'b1;
    end else begin
      start_q <= btn_start;
      clear_q <= btn_clear;
    end
  end

  assign start_edge = btn_start & ~start_q;
  assign clear_edge = btn_clear & ~clear_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Clear has priority over start from every state.
  always_comb begin
    state_nxt = state;
    if (clear_edge) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        IDLE:    if (start_edge) state_nxt = RUN;
        RUN:     if (start_edge) state_nxt = PAUSE;
        PAUSE:   if (start_edge) state_nxt = RUN;
        CLEAR:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    run     = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      RUN:     run     = 1'b1;
      CLEAR:   cnt_clr = 1'b1;
      default: ;
    endcase
  end

  // Prescaler counts every RUN cycle; a wrap on the way out of RUN drops its tick.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        RUN: begin
          if (p == P_MAX) begin
            p      <= '0;
            tick_q <= (state_nxt == RUN);
          end else begin
            p <= p + 1'b1;
          end
        end
        PAUSE:   p <= p;
        default: p <= '0;
      endcase
    end
  end

  assign cnt_tick = tick_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sdiv <= '0;
      k    <= 2'd0;
    end else if (sdiv == S_MAX) begin
      sdiv <= '0;
      k    <= k + 2'd1;
    end else begin
      sdiv <= sdiv + 1'b1;
    end
  end

  // ---- p0: digit select and decode
  assign nib_p0 = bcdcount[{k, 2'b00} +: 4];

  seg7_decode u_dec (
    .nib (nib_p0),
    .seg (dec_p0)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_p0 = 1'b0;
    case (k)
      2'd3:    blank_p0 = (bcdcount[15:12] == 4'd0);
      2'd2:    blank_p0 = (bcdcount[15:8]  == 8'd0);
      2'd1:    blank_p0 = (bcdcount[15:4]  == 12'd0);
      default: blank_p0 = 1'b0;
    endcase
  end
`else
  assign blank_p0 = 1'b0;
`endif

  assign seg_p0 = blank_p0 ? SEG_BLANK : dec_p0;

  // ---- p1: registered display pins
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= 4'b1111;
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= ~(4'b0001 << k);
      seg_p1 <= seg_p0;
      dp_p1  <= ~((k == 2'd0) && (state == PAUSE));
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = dp_p1;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with TICK_DIV=4, SCAN_DIV=2.
// Honours LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_bcd_count_ctrl;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        btn_start;
  logic        btn_clear;
  logic [15:0] bcdcount;
  logic        cnt_tick;
  logic        cnt_clr;
  logic        run;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_tests = 0;
  int n_fail  = 0;
  int dp0_seen = 0;

  bcd_count_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .bcdcount  (bcdcount),
    .cnt_tick  (cnt_tick),
    .cnt_clr   (cnt_clr),
    .run       (run),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] tgt, input string tag);
    int n = 0;
    while (an !== tgt && n < 20) begin
      nxt();
      @(negedge sclk);
      n++;
    end
    chk(tag, an, tgt);
  endtask

  logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
`ifdef LEADING_ZERO_BLANK_EN
  logic [6:0] lead0_seg = 7'h7F;
`else
  logic [6:0] lead0_seg = 7'h40;
`endif

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; bcdcount = 16'h0000;
    repeat (3) nxt();
    @(negedge sclk);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_run", run, 1'b0);
    chk("rst_tick", cnt_tick, 1'b0);
    chk("rst_clr", cnt_clr, 1'b0);

    nxt(); rst_n = 1'b1;
    nxt(); @(negedge sclk);
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'h40);
    chk("first_dp", dp, 1'b1);

    // start from IDLE: ticks 4, 8, 12 cycles after RUN entry
    nxt(); btn_start = 1'b1;
    nxt(); btn_start = 1'b0; @(negedge sclk);
    chk("start_run", run, 1'b1);
    chk("start_tick0", cnt_tick, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      nxt(); @(negedge sclk);
      chk($sformatf("start_tick%0d", i), cnt_tick, (i % 4 == 0) ? 1'b1 : 1'b0);
    end

    // pause after two RUN cycles of the period
    nxt(); btn_start = 1'b1; @(negedge sclk);
    chk("pre_pause_run", run, 1'b1);
    nxt(); btn_start = 1'b0; @(negedge sclk);
    chk("pause_run", run, 1'b0);
    chk("pause_tick1", cnt_tick, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      nxt();
      if (i == 10) btn_start = 1'b1;
      @(negedge sclk);
      chk($sformatf("pause_tick%0d", i), cnt_tick, 1'b0);
      chk("pause_dp", dp, (an == 4'b1110) ? 1'b0 : 1'b1);
      if (dp == 1'b0) dp0_seen++;
    end
    chk("pause_dp_seen", (dp0_seen > 0) ? 1'b1 : 1'b0, 1'b1);

    nxt(); btn_start = 1'b0; @(negedge sclk);
    chk("resume_run", run, 1'b1);
    chk("resume_tick_r1", cnt_tick, 1'b0);
    nxt(); @(negedge sclk);
    chk("resume_tick_r2", cnt_tick, 1'b0);
    nxt(); @(negedge sclk);
    chk("resume_tick_r3", cnt_tick, 1'b1);
    nxt(); btn_start = 1'b1; btn_clear = 1'b1; @(negedge sclk);
    chk("resume_tick_r4", cnt_tick, 1'b0);

    // simultaneous start and clear: clear wins
    nxt(); btn_start = 1'b0; btn_clear = 1'b0; @(negedge sclk);
    chk("prec_clr", cnt_clr, 1'b1);
    chk("prec_run", run, 1'b0);
    chk("prec_tick", cnt_tick, 1'b0);
    nxt(); @(negedge sclk);
    chk("prec_idle_clr", cnt_clr, 1'b0);
    chk("prec_idle_run", run, 1'b0);
    chk("prec_idle_tick", cnt_tick, 1'b0);
    nxt(); @(negedge sclk);
    chk("prec_idle_run2", run, 1'b0);

    // start edge landing in CLEAR is ignored
    nxt(); btn_clear = 1'b1;
    nxt(); btn_clear = 1'b0; btn_start = 1'b1; @(negedge sclk);
    chk("clr2_clr", cnt_clr, 1'b1);
    nxt(); btn_start = 1'b0; @(negedge sclk);
    chk("clr2_run", run, 1'b0);
    chk("clr2_clr_off", cnt_clr, 1'b0);
    nxt(); @(negedge sclk);
    chk("clr2_run2", run, 1'b0);

    // scan order
    nxt(); bcdcount = 16'h1234;
    nxt(); @(negedge sclk);
    wait_an(4'b0111, "scan_sync");
    wait_an(4'b1110, "scan_start");
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("scan_an%0d_%0d", d, r), an, exp_an[d]);
        chk($sformatf("scan_seg%0d_%0d", d, r), seg, exp_seg[d]);
        nxt(); @(negedge sclk);
      end
    end

    // invalid digit
    nxt(); bcdcount = 16'h00A7;
    nxt(); @(negedge sclk);
    wait_an(4'b1101, "inv_an1");
    chk("inv_seg1", seg, 7'h7F);
    wait_an(4'b1110, "inv_an0");
    chk("inv_seg0", seg, 7'h78);

    // leading zeros
    nxt(); bcdcount = 16'h0007;
    nxt(); @(negedge sclk);
    wait_an(4'b0111, "lz_an3");
    chk("lz_seg3", seg, lead0_seg);
    wait_an(4'b1101, "lz_an1");
    chk("lz_seg1", seg, lead0_seg);
    wait_an(4'b1110, "lz_an0");
    chk("lz_seg0", seg, 7'h78);

    // async reset in RUN with start held through release
    nxt(); btn_start = 1'b1;
    nxt(); @(negedge sclk);
    chk("ar_pre_run", run, 1'b1);
    nxt(); #2 rst_n = 1'b0; #1;
    chk("ar_run", run, 1'b0);
    chk("ar_an", an, 4'b1111);
    chk("ar_seg", seg, 7'h7F);
    chk("ar_dp", dp, 1'b1);
    chk("ar_tick", cnt_tick, 1'b0);
    chk("ar_clr", cnt_clr, 1'b0);
    nxt(); nxt(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt(); @(negedge sclk);
      chk($sformatf("ar_hold_run%0d", i), run, 1'b0);
    end
    nxt(); btn_start = 1'b0; @(negedge sclk);
    chk("ar_rel_run", run, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
